// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: port identifiers and stall-counter sizing.
package dmem_arbiter_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    localparam int                 STALL_W   = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the cpu and dbg requesters.
// Latency: combinational grant from current requests and the last_win register.
// Backpressure: a losing requester holds its request and wins the next contested cycle.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dbg_req,
    output logic cpu_gnt,
    output logic dbg_gnt
);

    port_e last_win;
    logic  contested;

    assign contested = cpu_req & dbg_req;

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            if (contested) begin
                cpu_gnt = (last_win == PORT_DBG);
                dbg_gnt = (last_win == PORT_CPU);
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end
    end

    // Only contested cycles move the priority; lone requests leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_win <= PORT_DBG;
        end else if (contested) begin
            last_win <= cpu_gnt ? PORT_CPU : PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU and the debug/loader port.
// Latency: grant and mem strobe in the request cycle; load data returns one cycle later.
// Backpressure: an ungranted requester holds its fields; cpu stall cycles are counted.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cpu_req,
    input  logic                cpu_st,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    input  logic [DW/8-1:0]     cpu_be,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [DW-1:0]       cpu_rdata,

    input  logic                dbg_req,
    input  logic                dbg_st,
    input  logic [AW-1:0]       dbg_addr,
    input  logic [DW-1:0]       dbg_wdata,
    input  logic [DW/8-1:0]     dbg_be,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DW-1:0]       dbg_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    output logic [DW/8-1:0]     mem_be,
    input  logic [DW-1:0]       mem_rdata,

    output logic [STALL_W-1:0]  cpu_stall_cnt
);

    logic               pending;
    port_e              owner;
    logic [STALL_W-1:0] stall_cnt;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (cpu_req),
        .dbg_req (dbg_req),
        .cpu_gnt (cpu_gnt),
        .dbg_gnt (dbg_gnt)
    );

    // Grants are already zero in reset, so the mux yields all-zero mem outputs then.
    always_comb begin
        mem_en    = cpu_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_st;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_be    = cpu_be;
        end else if (dbg_gnt) begin
            mem_we    = dbg_st;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_be    = dbg_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            owner   <= PORT_CPU;
        end else begin
            pending <= mem_en & ~mem_we;
            owner   <= dbg_gnt ? PORT_DBG : PORT_CPU;
        end
    end

    // Gating with rst drops a response whose load was granted just before reset.
    assign cpu_rvalid = pending & ~rst & (owner == PORT_CPU);
    assign dbg_rvalid = pending & ~rst & (owner == PORT_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cpu_req && !cpu_gnt && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign cpu_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected cycle/response records,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 0, cpu_st = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic [3:0]  cpu_be = 0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 0, dbg_st = 0;
    logic [31:0] dbg_addr = 0, dbg_wdata = 0;
    logic [3:0]  dbg_be = 0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 0;
    logic [15:0] cpu_stall_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [73:0] v;
        logic        chk;
        logic [15:0] cnt;
        int          id;
    } cyc_t;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } resp_t;

    cyc_t  cyc_q[$];
    resp_t resp_q[$];
    int    cyc_id = 0;

    logic [31:0] mem [256];

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_st        (cpu_st),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_be        (cpu_be),
        .cpu_gnt       (cpu_gnt),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .dbg_req       (dbg_req),
        .dbg_st        (dbg_st),
        .dbg_addr      (dbg_addr),
        .dbg_wdata     (dbg_wdata),
        .dbg_be        (dbg_be),
        .dbg_gnt       (dbg_gnt),
        .dbg_rvalid    (dbg_rvalid),
        .dbg_rdata     (dbg_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_rdata     (mem_rdata),
        .cpu_stall_cnt (cpu_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Synchronous memory: read data appears the cycle after the load strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_be);
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    cyc_t  mc;
    resp_t mr;
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mc = cyc_q.pop_front();
            checks++;
            if ({dbg_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_be,
                 dbg_rvalid, cpu_rvalid} !== mc.v) begin
                errors++;
                $display("FAIL cyc%0d gnt/mem/rvalid: got %h expected %h", mc.id,
                         {dbg_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_be,
                          dbg_rvalid, cpu_rvalid}, mc.v);
            end
            if (mc.chk) begin
                checks++;
                if (cpu_stall_cnt !== mc.cnt) begin
                    errors++;
                    $display("FAIL cyc%0d stall_cnt: got %h expected %h", mc.id,
                             cpu_stall_cnt, mc.cnt);
                end
            end
        end
        if (cpu_rvalid || dbg_rvalid) begin
            checks++;
            if (resp_q.size() == 0 || (cpu_rvalid && dbg_rvalid)) begin
                errors++;
                $display("FAIL unexpected rvalid: cpu=%b dbg=%b queued=%0d",
                         cpu_rvalid, dbg_rvalid, resp_q.size());
            end else begin
                mr = resp_q.pop_front();
                if ({dbg_rvalid, dbg_rvalid ? dbg_rdata : cpu_rdata} !== mr) begin
                    errors++;
                    $display("FAIL response port/data: got %b/%h expected %b/%h",
                             dbg_rvalid, dbg_rvalid ? dbg_rdata : cpu_rdata,
                             mr.port, mr.data);
                end
            end
        end
    end

    task automatic step(input logic r,
                        input logic cr, input logic cs, input logic [31:0] ca, input logic [31:0] cw,
                        input logic dr, input logic ds, input logic [31:0] da, input logic [31:0] dw,
                        input logic [3:0] db,
                        input logic [1:0] eg, input logic [1:0] erv,
                        input logic chk, input logic [15:0] ecnt,
                        input logic rsp, input logic [31:0] edata);
        cyc_t        c;
        resp_t       e;
        logic [31:0] xa, xw;
        logic [3:0]  xb;
        logic        xwe;
        @(posedge clk);
        #1;
        rst = r;
        cpu_req = cr; cpu_st = cs; cpu_addr = ca; cpu_wdata = cw; cpu_be = 4'hF;
        dbg_req = dr; dbg_st = ds; dbg_addr = da; dbg_wdata = dw; dbg_be = db;
        xa = '0; xw = '0; xb = '0; xwe = 1'b0;
        if (eg == 2'b01) begin
            xa = ca; xw = cw; xb = 4'hF; xwe = cs;
        end else if (eg == 2'b10) begin
            xa = da; xw = dw; xb = db; xwe = ds;
        end
        c.v   = {eg, |eg, xwe, xa, xw, xb, erv};
        c.chk = chk;
        c.cnt = ecnt;
        c.id  = cyc_id++;
        cyc_q.push_back(c);
        if (rsp) begin
            e.port = eg[1];
            e.data = edata;
            resp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic [1:0] erv, input logic chk, input logic [15:0] ecnt);
        step(0, 0,0,0,0, 0,0,0,0,4'h0, 2'b00, erv, chk, ecnt, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h200 >> 2] = 32'h11110200;
        mem[32'h204 >> 2] = 32'h11110204;
        mem[32'h208 >> 2] = 32'h11110208;
        mem[32'h300 >> 2] = 32'h22220300;
        mem[32'h304 >> 2] = 32'h22220304;

        // Reset with both requesting: no grants, counter clear.
        step(1, 1,0,32'h200,0, 1,0,32'h300,0,4'hF, 2'b00, 2'b00, 0, 16'h0, 0, 0);
        step(1, 1,0,32'h200,0, 1,0,32'h300,0,4'hF, 2'b00, 2'b00, 1, 16'h0, 0, 0);
        // Contention: cpu wins first, then strict alternation.
        step(0, 1,0,32'h200,0, 1,0,32'h300,0,4'hF, 2'b01, 2'b00, 1, 16'h0, 1, 32'h11110200);
        step(0, 1,0,32'h204,0, 1,0,32'h300,0,4'hF, 2'b10, 2'b01, 1, 16'h0, 1, 32'h22220300);
        step(0, 1,0,32'h204,0, 1,0,32'h304,0,4'hF, 2'b01, 2'b10, 1, 16'h1, 1, 32'h11110204);
        step(0, 1,0,32'h208,0, 1,0,32'h304,0,4'hF, 2'b10, 2'b01, 1, 16'h1, 1, 32'h22220304);
        idle(2'b10, 1, 16'h2);
        // CPU-only load.
        step(0, 1,0,32'h100,0, 0,0,0,0,4'h0, 2'b01, 2'b00, 1, 16'h2, 1, 32'hDEADBEEF);
        idle(2'b01, 1, 16'h2);
        // Dbg store, then cpu load of the same word, then back-to-back load.
        step(0, 0,0,0,0, 1,1,32'h40,32'h12345678,4'hF, 2'b10, 2'b00, 0, 16'h0, 0, 0);
        step(0, 1,0,32'h40,0, 0,0,0,0,4'h0, 2'b01, 2'b00, 0, 16'h0, 1, 32'h12345678);
        step(0, 1,0,32'h100,0, 0,0,0,0,4'h0, 2'b01, 2'b01, 0, 16'h0, 1, 32'hDEADBEEF);
        idle(2'b01, 0, 16'h0);
        // Dbg store with zero byte enables goes out unchanged.
        step(0, 0,0,0,0, 1,1,32'h40,32'hFFFFFFFF,4'h0, 2'b10, 2'b00, 0, 16'h0, 0, 0);
        step(0, 1,0,32'h40,0, 0,0,0,0,4'h0, 2'b01, 2'b00, 0, 16'h0, 1, 32'h12345678);
        idle(2'b01, 1, 16'h2);
        // Reset right after a cpu load grant: that response never appears.
        step(0, 1,0,32'h100,0, 0,0,0,0,4'h0, 2'b01, 2'b00, 0, 16'h0, 0, 0);
        step(1, 0,0,0,0, 0,0,0,0,4'h0, 2'b00, 2'b00, 0, 16'h0, 0, 0);
        idle(2'b00, 1, 16'h0);
        // Saturation: preload the counter, then three stall cycles under contention.
        @(negedge clk);
        #2;
        dut.stall_cnt = 16'hFFFE;
        step(0, 1,0,32'h100,0, 1,0,32'h300,0,4'hF, 2'b01, 2'b00, 1, 16'hFFFE, 1, 32'hDEADBEEF);
        step(0, 1,0,32'h100,0, 1,0,32'h300,0,4'hF, 2'b10, 2'b01, 1, 16'hFFFE, 1, 32'h22220300);
        step(0, 1,0,32'h100,0, 1,0,32'h300,0,4'hF, 2'b01, 2'b10, 1, 16'hFFFF, 1, 32'hDEADBEEF);
        step(0, 1,0,32'h100,0, 1,0,32'h300,0,4'hF, 2'b10, 2'b01, 1, 16'hFFFF, 1, 32'h22220300);
        step(0, 1,0,32'h100,0, 1,0,32'h300,0,4'hF, 2'b01, 2'b10, 1, 16'hFFFF, 1, 32'hDEADBEEF);
        step(0, 1,0,32'h100,0, 1,0,32'h300,0,4'hF, 2'b10, 2'b01, 1, 16'hFFFF, 1, 32'h22220300);
        idle(2'b10, 1, 16'hFFFF);
        idle(2'b00, 1, 16'hFFFF);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (resp_q.size() != 0 || cyc_q.size() != 0) begin
            errors++;
            $display("FAIL drain: responses left %0d cycles left %0d expected 0/0",
                     resp_q.size(), cyc_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
